// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: hazard sequencer state and register index
package cpu_types_pkg;

    localparam int REGADDR_W = 5;

    typedef logic [REGADDR_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALT    = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/hazard_stats.sv
// rtl/hazard_stats.sv - saturating stall/flush/memwait event counters
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   inc_stall            count one load-use stall cycle
//   inc_flush            count one redirect flush cycle
//   inc_memwait          count one data-wait cycle
//   freeze               hold all counters (core halted)
//   stat_stall/flush/memwait  counter values, saturate at all-ones
module hazard_stats #(
    parameter int STATCNT_W = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 inc_stall,
    input  logic                 inc_flush,
    input  logic                 inc_memwait,
    input  logic                 freeze,
    output logic [STATCNT_W-1:0] stat_stall,
    output logic [STATCNT_W-1:0] stat_flush,
    output logic [STATCNT_W-1:0] stat_memwait
);

    localparam logic [STATCNT_W-1:0] CNT_ONE = STATCNT_W'(1);
    localparam logic [STATCNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_stall   <= '0;
            stat_flush   <= '0;
            stat_memwait <= '0;
        end else if (!freeze) begin
            if (inc_stall && stat_stall != CNT_MAX)
                stat_stall <= stat_stall + CNT_ONE;
            if (inc_flush && stat_flush != CNT_MAX)
                stat_flush <= stat_flush + CNT_ONE;
            if (inc_memwait && stat_memwait != CNT_MAX)
                stat_memwait <= stat_memwait + CNT_ONE;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
//
// Optional feature macro: HAZARD_STATS_EN (adds stat_stall/stat_flush/stat_memwait).
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   ihit                 instruction fetch completes this cycle
//   dmem_req, dhit       MEM-stage data access pending / completing
//   id_rs, id_rt         source indices of the instruction in decode
//   ex_memread, ex_rt    load in EX and its destination
//   ex_redirect          EX resolved a taken branch or jump
//   mem_halt             halt instruction in MEM
//   pc_en                PC update enable
//   *_en                 pipeline register enables
//   *_flush              pipeline register bubble insert (overrides enable)
//   redirect_sel         PC mux selects the EX target
//   halted               core has halted
module pipe_hazard_ctrl #(
    parameter int REGADDR_W = 5,
    parameter int STATCNT_W = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 ihit,
    input  logic                 dmem_req,
    input  logic                 dhit,
    input  logic [REGADDR_W-1:0] id_rs,
    input  logic [REGADDR_W-1:0] id_rt,
    input  logic                 ex_memread,
    input  logic [REGADDR_W-1:0] ex_rt,
    input  logic                 ex_redirect,
    input  logic                 mem_halt,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 exmem_flush,
    output logic                 redirect_sel,
`ifdef HAZARD_STATS_EN
    output logic [STATCNT_W-1:0] stat_stall,
    output logic [STATCNT_W-1:0] stat_flush,
    output logic [STATCNT_W-1:0] stat_memwait,
`endif
    output logic                 halted
);

    import cpu_types_pkg::*;

    hazard_state_t state, state_nxt;
    logic          redir_pend, redir_pend_nxt;

    logic dwait, load_use, redir, active;
    logic rule_wait, rule_halt, rule_redir, rule_lu, rule_miss, rule_run;

    assign dwait    = dmem_req & ~dhit;
    assign load_use = ex_memread & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
    assign redir    = ex_redirect | redir_pend;

    // RUN and MEMWAIT share one priority ladder; HALT ignores every input.
    assign active     = (state != HALT);
    assign rule_wait  = active & dwait;
    assign rule_halt  = active & ~dwait & mem_halt;
    assign rule_redir = active & ~dwait & ~mem_halt & redir;
    assign rule_lu    = active & ~dwait & ~mem_halt & ~redir & load_use;
    assign rule_miss  = active & ~dwait & ~mem_halt & ~redir & ~load_use & ~ihit;
    assign rule_run   = active & ~dwait & ~mem_halt & ~redir & ~load_use & ihit;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= RUN;
            redir_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            redir_pend <= redir_pend_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        redir_pend_nxt = redir_pend;
        if (rule_wait) begin
            state_nxt = MEMWAIT;
            // A redirect seen while memory is frozen must survive until the thaw.
            if (ex_redirect)
                redir_pend_nxt = 1'b1;
        end else if (rule_halt) begin
            state_nxt = HALT;
        end else if (rule_redir) begin
            state_nxt      = RUN;
            redir_pend_nxt = 1'b0;
        end else if (active) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_en     = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        redirect_sel = 1'b0;
        halted       = 1'b0;
        // Outputs are held quiet while reset is asserted, whatever the inputs do.
        if (nRST) begin
            halted = (state == HALT);
            if (rule_halt) begin
                // Let the halt retire into WB while a bubble follows it.
                memwb_en    = 1'b1;
                exmem_flush = 1'b1;
            end
            if (rule_redir) begin
                pc_en        = 1'b1;
                redirect_sel = 1'b1;
                ifid_en      = 1'b1;
                idex_en      = 1'b1;
                exmem_en     = 1'b1;
                memwb_en     = 1'b1;
                ifid_flush   = 1'b1;
                idex_flush   = 1'b1;
            end
            if (rule_lu) begin
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                idex_flush = 1'b1;
            end
            if (rule_miss) begin
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                ifid_flush = 1'b1;
            end
            if (rule_run) begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    hazard_stats #(
        .STATCNT_W (STATCNT_W)
    ) u_stats (
        .CLK          (CLK),
        .nRST         (nRST),
        .inc_stall    (rule_lu),
        .inc_flush    (rule_redir),
        .inc_memwait  (rule_wait),
        .freeze       (state == HALT),
        .stat_stall   (stat_stall),
        .stat_flush   (stat_flush),
        .stat_memwait (stat_memwait)
    );
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline of one core.
- Drives the EN and flush inputs of the fetch/decode, decode/execute, execute/memory and memory/writeback pipeline registers, plus the PC enable.
- Arbitrates between cache waits, load-use hazards, branch/jump redirects and halt.
- Holds redirects that arrive during memory freezes and sequences the halt drain.

Parameters:
- REGADDR_W, 5, width of a register-file index.
- STATCNT_W, 32, width of the statistics counters (optional feature only).

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- ihit  input  1  instruction fetch completes this cycle.
- dmem_req  input  1  MEM stage has a data read or write pending.
- dhit  input  1  data access completes this cycle.
- id_rs  input  REGADDR_W  rs index of the instruction in decode.
- id_rt  input  REGADDR_W  rt index of the instruction in decode.
- ex_memread  input  1  instruction in EX is a load.
- ex_rt  input  REGADDR_W  destination of the load in EX.
- ex_redirect  input  1  EX resolved a taken branch or jump.
- mem_halt  input  1  halt instruction is in MEM.
- pc_en  output  1  PC register update enable.
- ifid_en, idex_en, exmem_en, memwb_en  output  1 each  pipeline register enables.
- ifid_flush, idex_flush, exmem_flush  output  1 each  load bubble (all zero); flush overrides EN.
- redirect_sel  output  1  PC mux selects the EX target.
- halted  output  1  core has halted.

Behaviour:
- State register: RUN, MEMWAIT, HALT. Also a sticky flag redir_pend.
- Reset (async, nRST=0): state RUN, redir_pend 0.
- Outputs are combinational from state, redir_pend and the current inputs. During reset all enables are 0, all flushes are 0, halted is 0 and redirect_sel is 0.
- dwait is defined as dmem_req & ~dhit.
- load_use is defined as ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- redir is defined as ex_redirect | redir_pend.
- Per-cycle priority in RUN and MEMWAIT (first match wins):
  1. dwait:
     - All enables are 0 and all flushes are 0.
     - Next state is MEMWAIT.
     - If ex_redirect is 1, redir_pend is set to 1.
  2. mem_halt:
     - memwb_en is 1. pc_en, ifid_en, idex_en and exmem_en are 0.
     - exmem_flush is 1.
     - Next state is HALT.
  3. redir:
     - pc_en is 1 and redirect_sel is 1.
     - All enables are 1. ifid_flush and idex_flush are 1.
     - redir_pend is cleared. Next state is RUN.
     - The redirect applies regardless of ihit, because the wrong-path fetch is abandoned.
  4. load_use:
     - pc_en is 0 and ifid_en is 0. idex_flush is 1.
     - exmem_en and memwb_en are 1.
     - ihit is ignored.
  5. ~ihit:
     - pc_en is 0. ifid_flush is 1. All other enables are 1.
  6. Otherwise all enables are 1 and no flushes are asserted.
- MEMWAIT returns to RUN on the first cycle dwait is 0. That exit cycle is evaluated with rules 2 to 6.
- HALT is absorbing until reset:
  - halted is 1.
  - All enables are 0 and all flushes are 0.
  - All inputs are ignored.
- ex_rt == 0 never causes a stall.
- A redirect and a load-use in the same cycle resolve as a redirect, because the dependent instruction is squashed.
- Reset asserted mid-MEMWAIT or mid-HALT returns to RUN with redir_pend cleared.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, three extra output ports are present: stat_stall, stat_flush and stat_memwait, each STATCNT_W wide.
- stat_stall increments on each load_use cycle that is not preempted by a higher rule.
- stat_flush increments on each cycle in which rule 3 applies.
- stat_memwait increments on each rule-1 cycle.
- The counters saturate at all-ones, reset to 0, and freeze in HALT.
- When the macro is undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- The state enum hazard_state_t (RUN, MEMWAIT, HALT) goes in cpu_types_pkg, together with regbits_t sized by REGADDR_W.
- One natural sub-module, hazard_stats, containing the saturating counters. It is instantiated only under HAZARD_STATS_EN.
- The control logic stays flat.

Test Plan:
- Reset release with ihit=1 and no hazards:
  - pc_en, ifid_en, idex_en, exmem_en and memwb_en are 1. All flushes are 0. halted is 0.
- Load-use, ex_memread=1, ex_rt=8, id_rt=8:
  - pc_en=0, ifid_en=0, idex_flush=1 for exactly that cycle.
  - Repeat with ex_rt=0: no stall.
- Redirect during a data miss:
  - Stimulus: dmem_req=1, dhit=0 for 3 cycles, ex_redirect pulsed in cycle 1.
  - Required: all enables 0 for 3 cycles.
  - Cycle 4 (dhit=1): redirect_sel=1, ifid_flush=1, idex_flush=1.
  - Cycle 5: normal running.
- Redirect concurrent with load_use and ihit=0:
  - Required: redirect_sel=1, pc_en=1, ifid_flush=1, idex_flush=1, no idex stall.
- Halt:
  - Stimulus: mem_halt=1 with dmem_req=0.
  - Same cycle: memwb_en=1, exmem_flush=1.
  - Next cycle onward: halted=1 and all enables 0, even with ihit toggling.
  - Assert nRST: returns to RUN.
- With HAZARD_STATS_EN:
  - Stimulus: 2 load-use cycles, 1 redirect, 3 memwait cycles.
  - Required: stat_stall=2, stat_flush=1, stat_memwait=3.
  - Preload to all-ones and verify saturation.
